// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command-level master: command codes,
// FSM state encoding and parameter defaults.
package i2c_pkg;

   localparam logic [1:0] CMD_START = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_STOP  = 2'd3;

   localparam int QDIV_DEF      = 125;
   localparam int TO_CYCLES_DEF = 3400000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP
   } state_t;

endpackage

// File: rtl/i2c_qtimer.sv
// Quarter-period counter: counts QDIV cycles per SCL quarter, holds while
// frozen, and strobes done on the last cycle of each quarter.
module i2c_qtimer #(
   parameter int QDIV = 125
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic freeze,
   output logic first,
   output logic done
);

   localparam logic [9:0] LAST = 10'(QDIV - 1);

   logic [9:0] cnt;

   assign first = (cnt == 10'd0);
   assign done  = !clear && !freeze && (cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (!freeze)
         cnt <= (cnt == LAST) ? 10'd0 : cnt + 10'd1;
   end

endmodule

// File: rtl/i2c_master_cmd.sv
// Command-driven I2C master: executes START/WRITE/READ/STOP one at a time on
// open-drain SDA/SCL, with clock-stretch support, timeout and arbitration.
module i2c_master_cmd
   import i2c_pkg::*;
#(
   parameter int QDIV      = QDIV_DEF,
   parameter int TO_CYCLES = TO_CYCLES_DEF,
   parameter int CW        = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wdata,
   input  logic       rd_nack,
   output logic       rsp_valid,
   output logic [7:0] rdata,
   output logic       nack,
   output logic       arb_lost,
   output logic       timeout,
   output logic       busy,
   input  logic       SDA_i,
   input  logic       SCL_i,
   output logic       SDA_t,
   output logic       SCL_t,
   output logic       SDA_o,
   output logic       SCL_o,
   output state_t     fsm_state
);

   state_t          state, state_n;
   logic [1:0]      q;
   logic            q_first, q_done, q_end;
   logic [2:0]      bcnt;
   logic [7:0]      sh;
   logic            smp;
   logic [1:0]      cmd_r;
   logic            rdn_r;
   logic            hold_low;
   logic [CW-1:0]   to_cnt;
   logic            accept, stretch, sample, arb_hit, to_hit;

   assign SDA_o     = 1'b0;
   assign SCL_o     = 1'b0;
   assign busy      = (state != ST_IDLE);
   assign cmd_ready = (state == ST_IDLE);
   assign fsm_state = state;
   assign accept    = cmd_valid && cmd_ready;

   // A slave holding SCL low while we release it freezes the quarter timer.
   assign stretch = busy && SCL_t && !SCL_i;
   assign q_end   = q_done && (q == 2'd3);
   assign sample  = ((state == ST_BIT) || (state == ST_ACK)) && (q == 2'd3) && q_first && !stretch;
   assign arb_hit = (state == ST_BIT) && (cmd_r == CMD_WRITE) && sample && sh[7] && !SDA_i;
   assign to_hit  = stretch && (to_cnt == CW'(TO_CYCLES - 1));

   i2c_qtimer #(.QDIV(QDIV)) u_qtimer (
      .clock  (clock),
      .reset  (reset),
      .clear  (!busy),
      .freeze (stretch),
      .first  (q_first),
      .done   (q_done)
   );

   // Between commands SCL stays low after START/WRITE/READ so SDA may move freely.
   always_comb begin
      SDA_t = 1'b1;
      SCL_t = 1'b1;
      case (state)
         ST_IDLE:  SCL_t = !hold_low;
         ST_START: begin
            SDA_t = (q == 2'd0);
            SCL_t = (q <= 2'd1);
         end
         ST_BIT: begin
            SCL_t = q[1];
            SDA_t = (cmd_r == CMD_WRITE) ? sh[7] : 1'b1;
         end
         ST_ACK: begin
            SCL_t = q[1];
            SDA_t = (cmd_r == CMD_WRITE) ? 1'b1 : rdn_r;
         end
         ST_STOP: begin
            SCL_t = (q != 2'd0);
            SDA_t = q[1];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd)
                  CMD_START: state_n = ST_START;
                  CMD_STOP:  state_n = ST_STOP;
                  default:   state_n = ST_BIT;
               endcase
            end
         end
         ST_START: if (q_end) state_n = ST_IDLE;
         ST_BIT:   if (q_end && (bcnt == 3'd0)) state_n = ST_ACK;
         ST_ACK:   if (q_end) state_n = ST_IDLE;
         ST_STOP:  if (q_end) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
      if (to_hit || arb_hit)
         state_n = ST_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q         <= '0;
         bcnt      <= '0;
         sh        <= '0;
         smp       <= 1'b0;
         cmd_r     <= '0;
         rdn_r     <= 1'b0;
         hold_low  <= 1'b0;
         to_cnt    <= '0;
         rsp_valid <= 1'b0;
         timeout   <= 1'b0;
         rdata     <= '0;
         nack      <= 1'b0;
         arb_lost  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         timeout   <= 1'b0;
         to_cnt    <= stretch ? to_cnt + CW'(1) : '0;
         if (!busy)
            q <= '0;
         else if (q_done)
            q <= q + 2'd1;
         if (accept) begin
            cmd_r <= cmd;
            sh    <= wdata;
            rdn_r <= rd_nack;
            bcnt  <= 3'd7;
         end
         if (sample)
            smp <= SDA_i;
         if (to_hit) begin
            timeout  <= 1'b1;
            hold_low <= 1'b0;
            to_cnt   <= '0;
         end else if (arb_hit) begin
            rsp_valid <= 1'b1;
            arb_lost  <= 1'b1;
            nack      <= 1'b0;
            hold_low  <= 1'b0;
         end else if (q_end) begin
            case (state)
               ST_START: begin
                  rsp_valid <= 1'b1;
                  arb_lost  <= 1'b0;
                  hold_low  <= 1'b1;
               end
               ST_BIT: begin
                  sh   <= {sh[6:0], smp};
                  bcnt <= bcnt - 3'd1;
               end
               ST_ACK: begin
                  rsp_valid <= 1'b1;
                  arb_lost  <= 1'b0;
                  hold_low  <= 1'b1;
                  if (cmd_r == CMD_WRITE)
                     nack <= smp;
                  else
                     rdata <= sh;
               end
               ST_STOP: begin
                  rsp_valid <= 1'b1;
                  arb_lost  <= 1'b0;
                  hold_low  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_cmd.sv
// Bench for i2c_master_cmd: open-drain bus with a behavioural slave, a second
// master for arbitration, and a clock-stretching helper.
module tb_i2c_master_cmd;
   import i2c_pkg::*;

   localparam int QDIV = 4;
   localparam int TO   = 100;
   localparam int M_NONE = 0, M_ACK = 1, M_READ = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready, rd_nack;
   logic [1:0] cmd;
   logic [7:0] wdata, rdata;
   logic       rsp_valid, nack, arb_lost, timeout, busy;
   logic       SDA_i, SCL_i, SDA_t, SCL_t, SDA_o, SCL_o;
   state_t     fsm_state;

   int         tests = 0;
   int         fails = 0;
   int         rsp_cnt = 0;
   int         mode;
   logic [7:0] rd_byte;
   logic       other_en, scl_hold, slave_low, other_low;
   int         fall_total = 0;
   int         fall_base, fall_k, rise_base;
   time        rise_t[$];
   logic       rise_sda[$];
   logic       rise_sdat[$];
   logic [7:0] exp_q[$];

   i2c_master_cmd #(.QDIV(QDIV), .TO_CYCLES(TO), .CW(8)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .wdata(wdata), .rd_nack(rd_nack), .rsp_valid(rsp_valid),
      .rdata(rdata), .nack(nack), .arb_lost(arb_lost), .timeout(timeout),
      .busy(busy), .SDA_i(SDA_i), .SCL_i(SCL_i), .SDA_t(SDA_t), .SCL_t(SCL_t),
      .SDA_o(SDA_o), .SCL_o(SCL_o), .fsm_state(fsm_state)
   );

   // clock / bus
   always #5 clock = ~clock;

   assign fall_k = fall_total - fall_base;
   assign SCL_i  = SCL_t & ~scl_hold;
   assign SDA_i  = SDA_t & ~slave_low & ~other_low;

   // Slave: data bit k is driven while SCL is low after the k-th falling edge.
   always_comb begin
      slave_low = 1'b0;
      if (mode == M_READ && fall_k >= 0 && fall_k < 8)
         slave_low = !rd_byte[7 - fall_k];
      else if (mode == M_ACK)
         slave_low = (fall_k == 8);
      other_low = other_en && (fall_k == 2);
   end

   always @(negedge SCL_i) fall_total++;

   always @(posedge SCL_i) begin
      rise_t.push_back($time);
      rise_sda.push_back(SDA_i);
      rise_sdat.push_back(SDA_t);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd_go(input logic [1:0] c, input logic [7:0] wd, input logic rn,
                         output logic got_rsp, output logic got_to);
      int n;
      @(posedge clock); #1;
      fall_base = fall_total;
      rise_base = rise_t.size();
      cmd = c; wdata = wd; rd_nack = rn; cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      got_rsp = 1'b0; got_to = 1'b0; n = 0;
      while (!got_rsp && !got_to && n < 3000) begin
         @(negedge clock);
         n++;
         if (rsp_valid) begin got_rsp = 1'b1; rsp_cnt++; end
         if (timeout) got_to = 1'b1;
      end
   endtask

   task automatic stretch_bit3(input int n);
      int seen, guard;
      seen = 0; guard = 0;
      @(posedge clock); #2;
      while (fall_k != 3 && guard < 2000) begin @(negedge clock); guard++; end
      scl_hold = 1'b1;
      while (guard < 4000) begin
         @(negedge clock);
         guard++;
         if (seen == n) break;
         if (SCL_t) seen++;
      end
      scl_hold = 1'b0;
   endtask

   function automatic logic [7:0] rx_byte(input int base);
      logic [7:0] b;
      b = 'x;
      for (int i = 0; i < 8; i++)
         b = {b[6:0], (base + i < rise_sda.size()) ? rise_sda[base + i] : 1'bx};
      return b;
   endfunction

   function automatic logic rx_at(input int idx, input logic use_t);
      if (idx >= rise_sda.size()) return 1'bx;
      return use_t ? rise_sdat[idx] : rise_sda[idx];
   endfunction

   // directed + randomized sequence with scoreboard
   initial begin
      logic       r, t, ack, rn;
      logic [7:0] wd;
      int         rb, op;
      reset = 1'b1; cmd_valid = 1'b0; cmd = '0; wdata = '0; rd_nack = 1'b0;
      mode = M_NONE; rd_byte = '0; other_en = 1'b0; scl_hold = 1'b0; fall_base = 0;
      rise_base = 0;
      repeat (3) @(posedge clock); #1;
      check("reset_outputs", {SDA_t, SCL_t, SDA_o, SCL_o, cmd_ready, busy, rsp_valid,
                              timeout, arb_lost, nack}, 10'b1100100000);
      check("reset_rdata", rdata, 8'h00);
      check("reset_state", fsm_state, ST_IDLE);
      reset = 1'b0;

      // START, WRITE 0xA5 acked, STOP
      rb = rsp_cnt;
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      check("start_sda_held_low_scl", SCL_t, 1'b0);
      mode = M_ACK;
      exp_q.push_back(8'hA5);
      cmd_go(CMD_WRITE, 8'hA5, 1'b0, r, t);
      check("wr_a5_bits", rx_byte(rise_base), exp_q.pop_front());
      check("wr_a5_ack_bit", rx_at(rise_base + 8, 1'b0), 1'b0);
      check("wr_a5_nack", nack, 1'b0);
      mode = M_NONE;
      cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);
      check("seq1_rsp_count", rsp_cnt - rb, 3);
      check("seq1_lines_released", {SDA_t, SCL_t, busy}, 3'b110);

      // READ 0x3C with master NACK
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      mode = M_READ; rd_byte = 8'h3C;
      exp_q.push_back(rd_byte);
      cmd_go(CMD_READ, 8'h00, 1'b1, r, t);
      check("rd_3c_rsp", r, 1'b1);
      check("rd_3c_rdata", rdata, exp_q.pop_front());
      check("rd_3c_ninth_sdat", rx_at(rise_base + 8, 1'b1), 1'b1);
      mode = M_NONE;
      cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);

      // WRITE 0x50, no slave
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      cmd_go(CMD_WRITE, 8'h50, 1'b0, r, t);
      check("wr_50_bits", rx_byte(rise_base), 8'h50);
      check("wr_50_nack", nack, 1'b1);
      cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);
      check("wr_50_stop_rsp", r, 1'b1);
      check("wr_50_stop_lines", {SDA_t, SCL_t}, 2'b11);

      // 50-cycle stretch in bit 3
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      mode = M_ACK;
      wd = 8'($urandom);
      fork
         cmd_go(CMD_WRITE, wd, 1'b0, r, t);
         stretch_bit3(50);
      join
      check("st50_period", 32'(rise_t[rise_base + 4] - rise_t[rise_base + 2]), (8 * QDIV + 50) * 10);
      check("st50_bits", rx_byte(rise_base), wd);
      check("st50_rsp_no_timeout", {r, t}, 2'b10);
      check("st50_nack", nack, 1'b0);
      mode = M_NONE;
      cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);

      // 100-cycle stretch -> timeout
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      mode = M_ACK;
      fork
         cmd_go(CMD_WRITE, 8'h81, 1'b0, r, t);
         stretch_bit3(TO);
      join
      check("to_pulse_no_rsp", {r, t}, 2'b01);
      check("to_lines_busy", {SDA_t, SCL_t, busy}, 3'b110);
      @(negedge clock);
      check("to_single_pulse", timeout, 1'b0);
      mode = M_NONE;

      // arbitration loss on bit 2
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      other_en = 1'b1;
      cmd_go(CMD_WRITE, 8'hFF, 1'b0, r, t);
      check("arb_rsp_lost", {r, arb_lost}, 2'b11);
      check("arb_lines_idle", {SDA_t, SCL_t, busy}, 3'b110);
      check("arb_bit_count", rise_t.size() - rise_base, 3);
      @(negedge clock);
      other_en = 1'b0;
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      check("arb_cleared_next_rsp", {r, arb_lost}, 2'b10);
      cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);

      // reset during READ bit 5
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      mode = M_READ; rd_byte = 8'h96;
      @(posedge clock); #1;
      fall_base = fall_total;
      cmd = CMD_READ; cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 2000 && fall_k != 5; i++) @(negedge clock);
      repeat (2) @(negedge clock);
      check("rst_mid_busy_before", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("rst_mid_release", {SDA_t, SCL_t, busy, cmd_ready}, 4'b1101);
      @(posedge clock); #1;
      check("rst_mid_outputs", {SDA_t, SCL_t, SDA_o, SCL_o, cmd_ready, busy, rsp_valid,
                                timeout, arb_lost, nack, rdata}, {10'b1100100000, 8'h00});
      reset = 1'b0;
      mode = M_NONE;
      cmd_go(CMD_START, 8'h00, 1'b0, r, t);
      check("rst_next_start", {r, t, SCL_t}, 3'b100);
      cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);
      check("rst_next_stop", r, 1'b1);

      // randomized transactions against the byte-level model
      for (int i = 0; i < 6; i++) begin
         op = $urandom_range(0, 1);
         cmd_go(CMD_START, 8'h00, 1'b0, r, t);
         if (op == 0) begin
            wd  = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            mode = ack ? M_ACK : M_NONE;
            exp_q.push_back(wd);
            cmd_go(CMD_WRITE, wd, 1'b0, r, t);
            check("rnd_wr_bits", rx_byte(rise_base), exp_q.pop_front());
            check("rnd_wr_nack", {r, nack}, {1'b1, !ack});
         end else begin
            rd_byte = 8'($urandom);
            rn = 1'($urandom_range(0, 1));
            mode = M_READ;
            exp_q.push_back(rd_byte);
            cmd_go(CMD_READ, 8'h00, rn, r, t);
            check("rnd_rd_rdata", {r, rdata}, {1'b1, exp_q.pop_front()});
            check("rnd_rd_ackbit", rx_at(rise_base + 8, 1'b1), rn);
         end
         mode = M_NONE;
         cmd_go(CMD_STOP, 8'h00, 1'b0, r, t);
         check("rnd_stop", {r, SDA_t, SCL_t}, 3'b111);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_master_cmd.md
I2C_MASTER_CMD -- requirements
Module: i2c_master_cmd

Interface
REQ-001 Parameter QDIV, default 125: clock cycles per SCL quarter-period, legal range 2..1023.
REQ-002 Parameter TO_CYCLES, default 3400000: maximum consecutive cycles a stretched SCL low is tolerated.
REQ-003 Parameter CW, default 26: width of the timeout counter, sized so that TO_CYCLES < 2^CW.
REQ-004 clock  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  block accepts a command this cycle.
REQ-008 cmd  in  2  command code: 0=START, 1=WRITE, 2=READ, 3=STOP.
REQ-009 wdata  in  8  byte for WRITE.
REQ-010 rd_nack  in  1  for READ, master answers NACK (1) or ACK (0).
REQ-011 rsp_valid  out  1  one-cycle pulse marking command completion.
REQ-012 rdata  out  8  byte received by READ, valid with rsp_valid.
REQ-013 nack  out  1  WRITE saw slave NACK, valid with rsp_valid.
REQ-014 arb_lost  out  1  arbitration lost, valid with rsp_valid.
REQ-015 timeout  out  1  one-cycle pulse on clock-stretch timeout.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 SDA_i, SCL_i  in  1 each  bus line levels, already synchronised externally.
REQ-018 SDA_t, SCL_t  out  1 each  tristate enable; 1 = released (high), 0 = drive low.
REQ-019 SDA_o, SCL_o  out  1 each  constant 0 (open-drain data).

Function
REQ-020 cmd_ready = (state==IDLE); a command is accepted on cmd_valid && cmd_ready, capturing cmd, wdata and rd_nack.
REQ-021 States: IDLE, START, BIT, ACK, STOP; 2-bit quarter index q and a QDIV-cycle quarter counter sequence each phase.
REQ-022 START: q0 SDA_t=1,SCL_t=1; q1 SDA_t=0; q2 SCL_t=0; q3 hold; then rsp_valid and IDLE; a repeated START issued while SCL is low works identically.
REQ-023 BIT, 8 bits MSB first: q0 SCL_t=0 and SDA_t set to data bit (WRITE) or 1 (READ); q1 hold; q2 SCL_t=1; q3 SCL high.
REQ-024 Sampling: SDA_i is sampled on the first cycle of q3; READ shifts it into rdata.
REQ-025 WRITE arbitration: a sampled 0 while SDA_t=1 sets arb_lost, releases both lines, and issues rsp_valid; the block enters IDLE with no STOP.
REQ-026 ACK phase: same quarter timing as BIT; WRITE releases SDA and sets nack = sampled SDA_i; READ drives SDA_t = rd_nack; rsp_valid pulses at end of q3 with SCL held low.
REQ-027 STOP: q0 SCL_t=0,SDA_t=0; q1 SCL_t=1; q2 SDA_t=1; q3 hold; rsp_valid; IDLE with both lines released.
REQ-028 Clock stretching: entering q3 of any phase requires SCL_i==1; while SCL_t=1 and SCL_i=0 the quarter counter freezes and the timeout counter increments.
REQ-029 The timeout counter clears whenever it is not stretching.
REQ-030 When the timeout counter reaches TO_CYCLES: timeout pulses, both lines are released, rsp_valid is not issued, and the state goes to IDLE.
REQ-031 Back-to-back: a command accepted the cycle after rsp_valid begins with no idle quarter.
REQ-032 cmd_valid while busy is ignored (no queuing).
REQ-033 Outputs rdata, nack and arb_lost hold their last value until the next rsp_valid.

Reset
REQ-034 While reset is asserted: state=IDLE, SDA_t=1, SCL_t=1, SDA_o=0, SCL_o=0, cmd_ready=1, busy=0, rsp_valid=0, timeout=0, arb_lost=0, nack=0, rdata=0, all counters 0.
REQ-035 Reset asserted mid-transfer releases the bus within the same cycle; no STOP is generated.

Structure
REQ-036 Shared package i2c_pkg holds the command-code constants, the state encoding, and the QDIV/TO_CYCLES defaults.
REQ-037 One sub-module, i2c_qtimer: quarter counter with freeze input, emitting a quarter-done strobe.

Verification (QDIV=4, TO_CYCLES=100, slave model)
REQ-038 START, WRITE 0xA5 with slave ACK, STOP -> SDA bits 1,0,1,0,0,1,0,1 on SCL rising edges; rsp_valid three times; nack=0; final SDA_t=SCL_t=1.
REQ-039 READ with slave sending 0x3C and rd_nack=1 -> rdata=0x3C; SDA_t=1 during the 9th SCL high.
REQ-040 WRITE 0x50 with no slave -> nack=1; next STOP completes normally.
REQ-041 Slave holds SCL low for 50 cycles during bit 3 -> bit period stretched by 50 cycles; data correct; timeout=0. Holding 100 cycles -> timeout pulse once, bus released, busy=0 next cycle.
REQ-042 WRITE 0xFF while another master pulls SDA low on bit 2 -> arb_lost=1 at that bit; SDA_t=SCL_t=1; IDLE.
REQ-043 reset pulsed mid-READ bit 5 -> all outputs at reset values; next START proceeds normally.
